// File: rtl/shift_right_seq.sv
// shift_right_seq: sequential 8-bit right shifter (logical/arithmetic),
// one bit position per clock, with start/busy/done handshake.
module shift_right_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [2:0] Amount,
  input  logic       Arith,
  output logic [7:0] Y,
  output logic       Carry,
  output logic       Zero,
  output logic       busy,
  output logic       done
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    y_q, y_d;
  logic [CW-1:0]   count_q, count_d;
  logic            carry_q, carry_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a zero amount skips SHIFT entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (Amount == CW'(0)) ? S_DONE : S_SHIFT;
      S_SHIFT: if (count_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and handshake next values; busy/done are decoded from the next state
  // so the registered copies line up with the state they describe
  always_comb begin
    y_d     = y_q;
    carry_d = carry_q;
    count_d = count_q;
    mode_d  = mode_q;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          y_d     = A;
          count_d = Amount;
          mode_d  = Arith;
          carry_d = 1'b0;
        end
      end
      S_SHIFT: begin
        y_d     = {(mode_q & y_q[W-1]), y_q[W-1:1]};
        carry_d = y_q[0];
        count_d = count_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      carry_q <= carry_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y     = y_q;
  assign Carry = carry_q;
  assign Zero  = (y_q == W'(0));
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
